// File: rtl/l3cache_evict_ctrl.sv
// l3cache_evict_ctrl: write-back sequencer for the L3 cache data array.
// Pops dirty line addresses, reads each line beat by beat from the data SRAM
// and streams it out as one AW/W/B burst. Also drains the FIFO on a flush
// request and pulses flush_done when the drain is complete.
// Optional build macro L3_EVICT_PIPE_EN: a 2-entry skid buffer between the
// SRAM read port and the W channel, sustaining one beat per cycle.
module l3cache_evict_ctrl #(
  parameter int LINE_LSB = 9,
  parameter int BEATS    = 2**(LINE_LSB-3),
  parameter int FIFO_AW  = 32-LINE_LSB
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               evict_busy,
  input  logic               fifo_empty,
  output logic               fifo_pop,
  input  logic [FIFO_AW-1:0] fifo_addr,
  output logic [31:0]        cache_addr,
  output logic               cache_en_r,
  input  logic [63:0]        cache_info_r,
  output logic               mem_aw_valid,
  input  logic               mem_aw_ready,
  output logic [31:0]        mem_aw_addr,
  output logic [7:0]         mem_aw_len,
  output logic               mem_w_valid,
  input  logic               mem_w_ready,
  output logic [63:0]        mem_w_data,
  output logic               mem_w_last,
  input  logic               mem_b_valid,
  output logic               mem_b_ready,
  input  logic [1:0]         mem_b_resp,
  output logic               evict_err
);

  localparam int              BW        = $clog2(BEATS);
  localparam logic [7:0]      AW_LEN    = 8'(BEATS-1);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_AW,
    S_RD,
    S_WD,
    S_BRESP
  } state_t;

`ifdef L3_EVICT_PIPE_EN
  // Streaming: the first read is issued with the AW handshake, and WD stays
  // put while beats flow through the skid buffer.
  localparam state_t AW_NEXT   = S_WD;
  localparam state_t BEAT_NEXT = S_WD;
`else
  // Alternating: every beat needs one RD cycle and at least one WD cycle.
  localparam state_t AW_NEXT   = S_RD;
  localparam state_t BEAT_NEXT = S_RD;
`endif

  state_t               state_q, state_d;
  logic [FIFO_AW-1:0]   line_q, line_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 err_q, err_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 w_hs;

  assign w_hs        = mem_w_valid && mem_w_ready;
  assign evict_busy  = (state_q != S_IDLE);
  assign evict_err   = err_q;
  assign mem_aw_addr = {line_q, {LINE_LSB{1'b0}}};
  assign mem_aw_len  = AW_LEN;
  assign mem_w_last  = mem_w_valid && (beat_q == LAST_BEAT);

  // Flush completes only once the FIFO is empty and no line is in flight.
  assign flush_done  = flush_pend_q && (state_q == S_IDLE) && fifo_empty;

  // Control state, line address, beat counter, sticky error, flush pending.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    beat_d       = beat_q;
    err_d        = err_q;
    flush_pend_d = flush_pend_q;
    fifo_pop     = 1'b0;
    mem_aw_valid = 1'b0;
    mem_b_ready  = 1'b0;

    if (flush_done) begin
      flush_pend_d = 1'b0;
    end else if (flush_req) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        // FIFO head is valid in the same cycle as the pop strobe.
        fifo_pop = 1'b1;
        line_d   = fifo_addr;
        state_d  = S_AW;
      end
      S_AW: begin
        mem_aw_valid = 1'b1;
        if (mem_aw_ready) begin
          beat_d  = '0;
          state_d = AW_NEXT;
        end
      end
      S_RD: begin
        state_d = S_WD;
      end
      S_WD: begin
        if (w_hs) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_BRESP;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = BEAT_NEXT;
          end
        end
      end
      S_BRESP: begin
        mem_b_ready = 1'b1;
        if (mem_b_valid) begin
          state_d = S_IDLE;
          if (mem_b_resp != 2'b00) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef L3_EVICT_PIPE_EN
  // ---------------------------------------------------------------------
  // Skid-buffered datapath. rd_cnt_q counts reads issued for the current
  // line (one extra bit so it can reach BEATS). A read in flight lands on
  // cache_info_r the following cycle; when the buffer is empty that word is
  // presented straight on W, otherwise it is queued behind older beats.
  // ---------------------------------------------------------------------
  logic [BW:0]   rd_cnt_q, rd_cnt_d;
  logic          inflight_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          hd_q, hd_d;
  logic [63:0]   buf_q [2];
  logic          buf_pop;
  logic          push;
  logic          wr_idx;
  logic [2:0]    occ_after;
  logic          aw_issue;
  logic          wd_issue;
  logic [BW-1:0] rd_beat;

  assign mem_w_valid = (state_q == S_WD) && ((cnt_q != 2'd0) || inflight_q);
  assign mem_w_data  = mem_w_valid ? ((cnt_q == 2'd0) ? cache_info_r : buf_q[hd_q]) : '0;

  // Slots still claimed after this cycle's W handshake: buffered + in flight.
  assign occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, w_hs};
  assign aw_issue  = (state_q == S_AW) && mem_aw_ready;
  assign wd_issue  = (state_q == S_WD) && !rd_cnt_q[BW] && (occ_after < 3'd2);
  assign cache_en_r = aw_issue || wd_issue;
  assign rd_beat    = aw_issue ? '0 : rd_cnt_q[BW-1:0];
  assign cache_addr = cache_en_r ? {line_q, rd_beat, 3'b000} : '0;

  // A returning word is buffered unless it goes straight out on W.
  assign buf_pop = w_hs && (cnt_q != 2'd0);
  assign push    = inflight_q && !(w_hs && (cnt_q == 2'd0));
  assign wr_idx  = hd_q ^ cnt_q[0];

  // Read-issue counter and buffer occupancy bookkeeping.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (aw_issue) begin
      rd_cnt_d = {{BW{1'b0}}, 1'b1};
    end else if (wd_issue) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, buf_pop};
    hd_d  = hd_q ^ buf_pop;
  end

  // Skid buffer storage and pointers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      hd_q       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      inflight_q <= cache_en_r;
      cnt_q      <= cnt_d;
      hd_q       <= hd_d;
      if (push) begin
        buf_q[wr_idx] <= cache_info_r;
      end
    end
  end
`else
  // ---------------------------------------------------------------------
  // Single-register datapath: RD issues the read, the first WD cycle sees
  // the SRAM word directly and latches it so W stays stable under stall.
  // ---------------------------------------------------------------------
  logic        wd_first_q;
  logic [63:0] w_data_q;

  assign cache_en_r  = (state_q == S_RD);
  assign cache_addr  = cache_en_r ? {line_q, beat_q, 3'b000} : '0;
  assign mem_w_valid = (state_q == S_WD);
  assign mem_w_data  = mem_w_valid ? (wd_first_q ? cache_info_r : w_data_q) : '0;

  // First-WD-cycle flag and W data holding register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wd_first_q <= 1'b0;
      w_data_q   <= '0;
    end else begin
      wd_first_q <= (state_q == S_RD);
      if ((state_q == S_WD) && wd_first_q) begin
        w_data_q <= cache_info_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l3cache_evict_ctrl.sv
// tb_l3cache_evict_ctrl: directed bench for the L3 write-back sequencer.
// Models the dirty FIFO, the 1-cycle-latency data SRAM and a memory slave.
`timescale 1ns/1ps
module tb_l3cache_evict_ctrl;
  localparam int BEATS = 64;
`ifdef L3_EVICT_PIPE_EN
  localparam int W_PHASE = 64;
`else
  localparam int W_PHASE = 128;
`endif

  logic        CLK;
  logic        RSTn = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic        evict_busy;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [22:0] fifo_addr;
  logic [31:0] cache_addr;
  logic        cache_en_r;
  logic [63:0] cache_info_r = '0;
  logic        mem_aw_valid;
  logic        mem_aw_ready = 1'b1;
  logic [31:0] mem_aw_addr;
  logic [7:0]  mem_aw_len;
  logic        mem_w_valid;
  logic        mem_w_ready = 1'b1;
  logic [63:0] mem_w_data;
  logic        mem_w_last;
  logic        mem_b_valid = 1'b0;
  logic        mem_b_ready;
  logic [1:0]  mem_b_resp = 2'b00;
  logic        evict_err;

  int checks = 0;
  int failures = 0;

  l3cache_evict_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .flush_req(flush_req), .flush_done(flush_done),
    .evict_busy(evict_busy), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_addr(fifo_addr), .cache_addr(cache_addr), .cache_en_r(cache_en_r),
    .cache_info_r(cache_info_r), .mem_aw_valid(mem_aw_valid),
    .mem_aw_ready(mem_aw_ready), .mem_aw_addr(mem_aw_addr),
    .mem_aw_len(mem_aw_len), .mem_w_valid(mem_w_valid),
    .mem_w_ready(mem_w_ready), .mem_w_data(mem_w_data),
    .mem_w_last(mem_w_last), .mem_b_valid(mem_b_valid),
    .mem_b_ready(mem_b_ready), .mem_b_resp(mem_b_resp), .evict_err(evict_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // SRAM contents as a function of byte address.
  function automatic logic [63:0] sram_word(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Dirty FIFO model
  logic [22:0] fmem [16];
  int fwr = 0;
  int frd = 0;
  assign fifo_empty = (fwr == frd);
  assign fifo_addr  = fmem[frd[3:0]];

  task automatic push(input logic [22:0] a);
    fmem[fwr[3:0]] = a;
    fwr++;
  endtask

  // Monitor state
  int cyc_now = 0, aw_cnt = 0, w_cnt = 0, beat_idx = 0, data_err = 0;
  int last_err = 0, last_cnt = 0, stab_err = 0, overlap = 0, pops = 0;
  int cen_cnt = 0, fd_cnt = 0, fd_cyc = 0, fr_cyc = 0, last_bhs_cyc = 0;
  int wlast_cnt = 0, bhs_cnt = 0, w_phase = 0, phase_cyc = 0;
  int err_sel = -1;
  bit counting = 0, prev_pend = 0, rnd_mode = 0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] cur_base = '0;
  logic [7:0]  aw_len_s = '0;
  logic [31:0] aw_log [$];
  logic        en_s = 1'b0, pop_s = 1'b0;
  logic [31:0] addr_s = '0;

  // Mid-cycle observer of every DUT output
  initial begin
    forever begin
      @(negedge CLK);
      cyc_now++;
      en_s = cache_en_r;
      addr_s = cache_addr;
      pop_s = fifo_pop;
      if (RSTn) begin
        if (fifo_pop) pops++;
        if (cache_en_r) cen_cnt++;
        if (mem_aw_valid && mem_w_valid) overlap++;
        if (flush_req) fr_cyc = cyc_now;
        if (flush_done) begin
          fd_cnt++;
          fd_cyc = cyc_now;
        end
        if (counting) phase_cyc++;
        if (prev_pend && (!mem_w_valid || mem_w_data !== prev_data || mem_w_last !== prev_last))
          stab_err++;
        prev_pend = mem_w_valid && !mem_w_ready;
        prev_data = mem_w_data;
        prev_last = mem_w_last;
        if (mem_aw_valid && mem_aw_ready) begin
          aw_cnt++;
          aw_log.push_back(mem_aw_addr);
          aw_len_s = mem_aw_len;
          cur_base = mem_aw_addr;
          beat_idx = 0;
          counting = 1;
          phase_cyc = 0;
        end
        if (mem_w_valid && mem_w_ready) begin
          w_cnt++;
          if (mem_w_data !== sram_word(cur_base + 32'(8 * beat_idx))) data_err++;
          if (mem_w_last !== (beat_idx == BEATS - 1)) last_err++;
          if (mem_w_last) begin
            last_cnt++;
            wlast_cnt++;
            w_phase = phase_cyc;
            counting = 0;
          end
          beat_idx++;
        end
        if (mem_b_valid && mem_b_ready) begin
          bhs_cnt++;
          last_bhs_cyc = cyc_now;
        end
      end
    end
  end

  // SRAM read port, FIFO pointer and memory slave, driven just after the edge
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (en_s) cache_info_r = sram_word(addr_s);
      if (pop_s && (frd != fwr)) frd++;
      mem_aw_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_w_ready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_b_valid  = (wlast_cnt > bhs_cnt);
      mem_b_resp   = (mem_b_valid && (bhs_cnt == err_sel)) ? 2'b10 : 2'b00;
    end
  end

  task automatic clear_stats();
    aw_cnt = 0; w_cnt = 0; data_err = 0; last_err = 0; last_cnt = 0;
    stab_err = 0; pops = 0; cen_cnt = 0; fd_cnt = 0; w_phase = 0;
    aw_log.delete();
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_bhs(input string tag, input int target, input int maxcyc);
    int n = 0;
    while (bhs_cnt < target && n < maxcyc) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check(tag, 64'(bhs_cnt), 64'(target));
  endtask

  function automatic logic [31:0] aw_at(input int i);
    return (aw_log.size() > i) ? aw_log[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic check_zero(input string p);
    check({p, "_busy"},   64'(evict_busy), 64'd0);
    check({p, "_pop"},    64'(fifo_pop), 64'd0);
    check({p, "_fdone"},  64'(flush_done), 64'd0);
    check({p, "_cen"},    64'(cache_en_r), 64'd0);
    check({p, "_caddr"},  64'(cache_addr), 64'd0);
    check({p, "_awv"},    64'(mem_aw_valid), 64'd0);
    check({p, "_awaddr"}, 64'(mem_aw_addr), 64'd0);
    check({p, "_awlen"},  64'(mem_aw_len), 64'd63);
    check({p, "_wv"},     64'(mem_w_valid), 64'd0);
    check({p, "_wdata"},  mem_w_data, 64'd0);
    check({p, "_wlast"},  64'(mem_w_last), 64'd0);
    check({p, "_bready"}, 64'(mem_b_ready), 64'd0);
    check({p, "_err"},    64'(evict_err), 64'd0);
  endtask

  initial begin
    int b0;
    for (int i = 0; i < 16; i++) fmem[i] = '0;
    repeat (3) tick();
    check_zero("rst");
    RSTn = 1'b1;
    tick();

    // T1: single line, bus always ready
    clear_stats();
    b0 = bhs_cnt;
    push(23'h000123);
    wait_bhs("t1_done", b0 + 1, 1000);
    check("t1_aw_addr", 64'(aw_at(0)), 64'h0002_4600);
    check("t1_aw_len", 64'(aw_len_s), 64'd63);
    check("t1_aw_cnt", 64'(aw_cnt), 64'd1);
    check("t1_beats", 64'(w_cnt), 64'd64);
    check("t1_data_err", 64'(data_err), 64'd0);
    check("t1_last_err", 64'(last_err), 64'd0);
    check("t1_last_cnt", 64'(last_cnt), 64'd1);
    check("t1_pops", 64'(pops), 64'd1);
    check("t1_w_phase", 64'(w_phase), 64'(W_PHASE));
    repeat (2) tick();
    check("t1_busy_after", 64'(evict_busy), 64'd0);

    // T2: random back-pressure on AW and W
    clear_stats();
    b0 = bhs_cnt;
    rnd_mode = 1;
    push(23'h000ABC);
    wait_bhs("t2_done", b0 + 1, 2000);
    rnd_mode = 0;
    check("t2_aw_addr", 64'(aw_at(0)), 64'h0015_7800);
    check("t2_beats", 64'(w_cnt), 64'd64);
    check("t2_data_err", 64'(data_err), 64'd0);
    check("t2_last_err", 64'(last_err), 64'd0);
    check("t2_stable_err", 64'(stab_err), 64'd0);
    repeat (2) tick();

    // T3: three queued lines then a flush
    clear_stats();
    b0 = bhs_cnt;
    push(23'h000010);
    push(23'h000011);
    push(23'h000012);
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_bhs("t3_done", b0 + 3, 3000);
    repeat (3) tick();
    check("t3_aw_cnt", 64'(aw_cnt), 64'd3);
    check("t3_aw2_addr", 64'(aw_at(2)), 64'h0000_2400);
    check("t3_beats", 64'(w_cnt), 64'd192);
    check("t3_data_err", 64'(data_err), 64'd0);
    check("t3_pops", 64'(pops), 64'd3);
    check("t3_fdone_cnt", 64'(fd_cnt), 64'd1);
    check("t3_fdone_cyc", 64'(fd_cyc), 64'(last_bhs_cyc + 1));
    check("t3_busy_after", 64'(evict_busy), 64'd0);

    // T4: flush with nothing to drain
    clear_stats();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (3) tick();
    check("t4_fdone_cnt", 64'(fd_cnt), 64'd1);
    check("t4_fdone_cyc", 64'(fd_cyc), 64'(fr_cyc + 1));
    check("t4_aw_cnt", 64'(aw_cnt), 64'd0);
    check("t4_cen_cnt", 64'(cen_cnt), 64'd0);

    // T5: error response on the first of two bursts
    clear_stats();
    b0 = bhs_cnt;
    err_sel = bhs_cnt;
    check("t5_err_before", 64'(evict_err), 64'd0);
    push(23'h000020);
    push(23'h000021);
    wait_bhs("t5_first", b0 + 1, 1000);
    tick();
    check("t5_err_rise", 64'(evict_err), 64'd1);
    wait_bhs("t5_second", b0 + 2, 1000);
    err_sel = -1;
    repeat (3) tick();
    check("t5_err_sticky", 64'(evict_err), 64'd1);
    check("t5_aw_cnt", 64'(aw_cnt), 64'd2);
    check("t5_beats", 64'(w_cnt), 64'd128);
    check("t5_data_err", 64'(data_err), 64'd0);

    // T6: asynchronous reset at beat 20, then a fresh burst
    clear_stats();
    push(23'h000007);
    for (int n = 0; n < 1000 && w_cnt < 20; n++) begin
      @(negedge CLK);
      #1;
    end
    check("t6_reach_beat20", 64'(w_cnt), 64'd20);
    RSTn = 1'b0;
    #1;
    check_zero("t6_rst");
    push(23'h000055);
    repeat (2) tick();
    clear_stats();
    b0 = bhs_cnt;
    RSTn = 1'b1;
    wait_bhs("t6_done", b0 + 1, 1000);
    check("t6_aw_addr", 64'(aw_at(0)), 64'h0000_AA00);
    check("t6_beats", 64'(w_cnt), 64'd64);
    check("t6_data_err", 64'(data_err), 64'd0);
    check("t6_last_err", 64'(last_err), 64'd0);
    check("t6_err_cleared", 64'(evict_err), 64'd0);

    check("aw_w_overlap", 64'(overlap), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l3cache_evict_ctrl.md
Name: l3cache_evict_ctrl

Overview:
- Write-back sequencer for the L3 cache data array.
- Pops dirty-line addresses from the dirty-block FIFO, reads each line beat-by-beat from the cache data SRAM (64-bit read port, 1-cycle latency), and streams it to memory over an AXI-style write channel (AW/W/B).
- Sits between the dirty-block FIFO, the cache_mem read port and the memory-side bus master.
- Also services explicit flush requests and signals completion.

Parameters:
- LINE_LSB, 9, log2 of line size in bytes (1024b x 4 banks / 8 = 512B).
- BEATS, 2**(LINE_LSB-3), 64-bit beats per line (64).
- FIFO_AW, 23, address width held in the dirty FIFO (32-LINE_LSB).

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- flush_req  in  1  level; request full drain of dirty FIFO
- flush_done  out  1  one-cycle pulse when a flush completes
- evict_busy  out  1  high whenever FSM not IDLE
- fifo_empty  in  1  dirty FIFO empty
- fifo_pop  out  1  one-cycle pop strobe
- fifo_addr  in  FIFO_AW  line address at FIFO head
- cache_addr  out  32  byte address of beat to read
- cache_en_r  out  1  SRAM read enable; data valid next cycle
- cache_info_r  in  64  SRAM read data
- mem_aw_valid  out  1  write-address valid
- mem_aw_ready  in  1  write-address ready
- mem_aw_addr  out  32  {line_addr, LINE_LSB'b0}
- mem_aw_len  out  8  BEATS-1
- mem_w_valid  out  1  write-data valid
- mem_w_ready  in  1  write-data ready
- mem_w_data  out  64  beat data
- mem_w_last  out  1  final beat of burst
- mem_b_valid  in  1  write-response valid
- mem_b_ready  out  1  write-response ready
- mem_b_resp  in  2  response; nonzero = error
- evict_err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0 except mem_aw_len (constant BEATS-1). Internal state: IDLE, beat counter 0, line register 0, error 0.
- FSM states: IDLE, POP, AW, RD, WD, BRESP.
- IDLE -> POP: when !fifo_empty.
- POP: assert fifo_pop for exactly one cycle and latch fifo_addr into the line register (head is valid in the same cycle as the pop). Then -> AW.
- AW: hold mem_aw_valid high with a stable address until mem_aw_ready. On the handshake, clear the beat counter and go -> RD.
- RD: assert cache_en_r for one cycle with cache_addr = {line, beat, 3'b0}. Then -> WD.
- WD: capture cache_info_r into the W data register on the first cycle of WD. Hold mem_w_valid and data stable until mem_w_ready.
  - mem_w_last = (beat == BEATS-1).
  - On handshake: if last -> BRESP, else beat+1 and -> RD.
- BRESP: mem_b_ready=1. On mem_b_valid -> IDLE. If mem_b_resp != 0, set evict_err (cleared only by reset).
- Throughput without the optional feature: one beat per 2 cycles minimum.
- The beat counter is $clog2(BEATS) bits and never wraps within a burst.
- flush handling:
  - Flush pending is set on flush_req while not pending.
  - flush_done pulses one cycle when pending && IDLE && fifo_empty; pending clears in the same cycle.
  - flush_req already active with FIFO empty and FSM IDLE gives flush_done on the next cycle.
- A new FIFO entry arriving while a line is in progress is not popped until the FSM returns to IDLE.
- Simultaneous flush_req and !fifo_empty in IDLE: the drain proceeds; flush_done waits until the FIFO is empty and the FSM is IDLE.
- Reset mid-burst returns immediately to reset values. An outstanding bus transaction is abandoned; the memory side shares the same reset.
- The AW and W channels are never asserted together. W starts only after the AW handshake.

Optional Feature:
- Macro: L3_EVICT_PIPE_EN.
- With macro: a 2-entry skid buffer sits between the SRAM and W.
  - The read of beat n+1 is issued in the cycle beat n enters the buffer, provided a free slot exists.
  - Sustains 1 beat/cycle when mem_w_ready stays high.
  - cache_en_r is never issued when both slots are full or outstanding.
  - Beat ordering and mem_w_last are unchanged.
- Without macro: the single-register RD/WD alternation described above.

Test Plan:
- Push addr 0x000123, mem ready always 1 -> AW addr 0x00024600, len 63; 64 W beats with data matching SRAM model at 0x24600+8k; last on beat 63; fifo_pop exactly once; 128 cycles of W phase without macro, 64 with it.
- mem_w_ready toggles 1/0 randomly -> mem_w_data/last stable while valid && !ready; no beat lost or duplicated.
- Three dirty entries queued, then flush_req=1 -> three sequential bursts; flush_done pulses once, one cycle after the final B handshake; evict_busy low afterward.
- flush_req with FIFO empty, FSM IDLE -> flush_done the next cycle, no bus activity.
- mem_b_resp=2'b10 on first burst -> evict_err rises and stays 1; the second burst still completes normally.
- RSTn asserted at beat 20 -> all outputs 0 asynchronously; after release with FIFO non-empty, a fresh burst starts at beat 0.
